branch_predictor_btb: RTL and testbench

//  Parametrised dynamic branch predictor for the 5-stage pipeline CPU. It sits beside the PC in IF and replaces

---
 rtl/bp_pkg.sv | 46 ++++
 rtl/branch_predictor_btb_if.sv | 28 ++
 rtl/bp_sat_counter.sv | 39 +++
 rtl/branch_predictor_btb.sv | 109 ++++++++++
 tb/tb_branch_predictor_btb.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the BTB branch predictor: counter encodings, saturation and PC field helpers.
package bp_pkg;

  localparam int unsigned CTR_MAX_W = 8;
  localparam int unsigned PC_MAX_W  = 64;

  typedef logic [CTR_MAX_W-1:0] ctr_t;
  typedef logic [PC_MAX_W-1:0]  pc_t;

  // Named encodings for the common 2-bit counter
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Weakly taken: MSB set, all lower bits clear
  function automatic ctr_t ctr_weak_taken(input int unsigned w);
    return ctr_t'(1) << (w - 1);
  endfunction

  // Weakly not-taken: MSB clear, all lower bits set (0 for a 1-bit counter)
  function automatic ctr_t ctr_weak_not_taken(input int unsigned w);
    return (ctr_t'(1) << (w - 1)) - ctr_t'(1);
  endfunction

  function automatic ctr_t ctr_max(input int unsigned w);
    return (ctr_t'(1) << w) - ctr_t'(1);
  endfunction

  // Saturating step towards the resolved outcome
  function automatic ctr_t sat_next(input ctr_t ctr, input logic taken, input int unsigned w);
    if (taken) return (ctr == ctr_max(w)) ? ctr : ctr + ctr_t'(1);
    else       return (ctr == ctr_t'(0))  ? ctr : ctr - ctr_t'(1);
  endfunction

  // Word-aligned index: pc[idx_w+1:2]
  function automatic pc_t pc_index(input pc_t pc, input int unsigned idx_w);
    return (pc >> 2) & ((pc_t'(1) << idx_w) - pc_t'(1));
  endfunction

  // Tag directly above the index: pc[idx_w+tag_w+1:idx_w+2]
  function automatic pc_t pc_tag(input pc_t pc, input int unsigned idx_w, input int unsigned tag_w);
    return (pc >> (idx_w + 2)) & ((pc_t'(1) << tag_w) - pc_t'(1));
  endfunction

endpackage

// File: rtl/branch_predictor_btb_if.sv
// Fetch-side lookup, resolution-side training and statistics bundle for the BTB predictor.
interface branch_predictor_btb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned STAT_W = 32
);
  logic              en_i;
  logic [ADDR_W-1:0] pred_pc_i;
  logic              pred_hit_o;
  logic              pred_taken_o;
  logic [ADDR_W-1:0] next_pc_o;
  logic              upd_valid_i;
  logic [ADDR_W-1:0] upd_pc_i;
  logic              upd_taken_i;
  logic [ADDR_W-1:0] upd_target_i;
  logic              upd_mispred_i;
  logic [STAT_W-1:0] stat_upd_o;
  logic [STAT_W-1:0] stat_miss_o;

  modport master (
    output en_i, pred_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_mispred_i,
    input  pred_hit_o, pred_taken_o, next_pc_o, stat_upd_o, stat_miss_o
  );

  modport slave (
    input  en_i, pred_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_mispred_i,
    output pred_hit_o, pred_taken_o, next_pc_o, stat_upd_o, stat_miss_o
  );
endinterface

// File: rtl/bp_sat_counter.sv
// Per-entry saturating up/down direction counter; resets weakly not-taken, loads weakly taken on allocate.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned CTR_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             upd_i,
  input  logic             load_i,
  input  logic             taken_i,
  output logic [CTR_W-1:0] ctr_o
);

  localparam logic [CTR_W-1:0] RST_VAL = CTR_W'(ctr_weak_not_taken(CTR_W));
  localparam logic [CTR_W-1:0] WT_VAL  = CTR_W'(ctr_weak_taken(CTR_W));

  logic [CTR_W-1:0] ctr_q;
  logic [CTR_W-1:0] ctr_d;

  // Allocation overrides training; otherwise step towards the outcome
  always_comb begin
    ctr_d = ctr_q;
    if (load_i) begin
      ctr_d = WT_VAL;
    end else if (upd_i) begin
      ctr_d = CTR_W'(sat_next(ctr_t'(ctr_q), taken_i, CTR_W));
    end
  end

  // Counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ctr_q <= RST_VAL;
    else       ctr_q <= ctr_d;
  end

  assign ctr_o = ctr_q;

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB predictor: combinational next-PC lookup in IF, training from ID resolution, stats.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned STAT_W  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  branch_predictor_btb_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [ADDR_W-1:0] addr_t;

  logic [ENTRIES-1:0] valid_q, valid_d;
  tag_t               tag_q    [ENTRIES];
  tag_t               tag_d    [ENTRIES];
  addr_t              target_q [ENTRIES];
  addr_t              target_d [ENTRIES];
  logic [CTR_W-1:0]   ctr      [ENTRIES];
  logic [STAT_W-1:0]  stat_upd_q, stat_upd_d;
  logic [STAT_W-1:0]  stat_miss_q, stat_miss_d;

  idx_t pred_idx, upd_idx;
  tag_t pred_tag, upd_tag;
  logic pred_hit, upd_hit, upd_alloc;

  assign pred_idx  = idx_t'(pc_index(pc_t'(bus.pred_pc_i), IDX_W));
  assign pred_tag  = tag_t'(pc_tag(pc_t'(bus.pred_pc_i), IDX_W, TAG_W));
  assign upd_idx   = idx_t'(pc_index(pc_t'(bus.upd_pc_i), IDX_W));
  assign upd_tag   = tag_t'(pc_tag(pc_t'(bus.upd_pc_i), IDX_W, TAG_W));
  assign pred_hit  = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
  assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_alloc = bus.upd_valid_i && !upd_hit && bus.upd_taken_i;

  // Lookup reads registered table state only, so same-cycle updates are not bypassed
  always_comb begin
    bus.pred_hit_o   = pred_hit;
    bus.pred_taken_o = pred_hit && bus.en_i && ctr[pred_idx][CTR_W-1];
    bus.next_pc_o    = bus.pred_taken_o ? target_q[pred_idx] : bus.pred_pc_i + addr_t'(4);
    bus.stat_upd_o   = stat_upd_q;
    bus.stat_miss_o  = stat_miss_q;
  end

  // Direction counters, one per entry
  for (genvar i = 0; i < int'(ENTRIES); i++) begin : g_ctr
    bp_sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .upd_i   (bus.upd_valid_i && upd_hit && (upd_idx == idx_t'(i))),
      .load_i  (upd_alloc && (upd_idx == idx_t'(i))),
      .taken_i (bus.upd_taken_i),
      .ctr_o   (ctr[i])
    );
  end

  // Taken resolutions refresh the target; taken misses also claim the slot
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (bus.upd_valid_i && bus.upd_taken_i) begin
      target_d[upd_idx] = bus.upd_target_i;
      if (!upd_hit) begin
        valid_d[upd_idx] = 1'b1;
        tag_d[upd_idx]   = upd_tag;
      end
    end
  end

  // Saturating statistics
  always_comb begin
    stat_upd_d  = stat_upd_q;
    stat_miss_d = stat_miss_q;
    if (bus.upd_valid_i && (stat_upd_q != '1)) begin
      stat_upd_d = stat_upd_q + STAT_W'(1);
    end
    if (bus.upd_valid_i && bus.upd_mispred_i && (stat_miss_q != '1)) begin
      stat_miss_d = stat_miss_q + STAT_W'(1);
    end
  end

  // Table and statistics registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      stat_upd_q  <= '0;
      stat_miss_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      target_q    <= target_d;
      stat_upd_q  <= stat_upd_d;
      stat_miss_q <= stat_miss_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: reset, allocate, saturation, aliasing, same-cycle and stats.
module tb_branch_predictor_btb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  branch_predictor_btb_if #(.ADDR_W(32), .STAT_W(4)) bus ();

  branch_predictor_btb #(
    .ADDR_W(32), .ENTRIES(16), .TAG_W(8), .CTR_W(2), .STAT_W(4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic idle_inputs();
    bus.en_i          = 1'b1;
    bus.pred_pc_i     = 32'h0;
    bus.upd_valid_i   = 1'b0;
    bus.upd_pc_i      = 32'h0;
    bus.upd_taken_i   = 1'b0;
    bus.upd_target_i  = 32'h0;
    bus.upd_mispred_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // One resolution committed on the next rising edge
  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt, input logic mis);
    @(negedge clk);
    bus.upd_valid_i   = 1'b1;
    bus.upd_pc_i      = pc;
    bus.upd_taken_i   = taken;
    bus.upd_target_i  = tgt;
    bus.upd_mispred_i = mis;
    @(posedge clk);
    #1;
    bus.upd_valid_i   = 1'b0;
    bus.upd_mispred_i = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    bus.pred_pc_i = pc;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    upd(32'h40, 1'b1, 32'h80, 1'b0);
    look(32'h40);
    total++; if (bus.pred_hit_o !== 1'b1) begin bad++; $display("FAIL rst_pre_hit got=%b exp=1", bus.pred_hit_o); end
    // Async assertion in the middle of a cycle
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    total++; if (bus.pred_hit_o !== 1'b0) begin bad++; $display("FAIL rst_hit got=%b exp=0", bus.pred_hit_o); end
    total++; if (bus.pred_taken_o !== 1'b0) begin bad++; $display("FAIL rst_taken got=%b exp=0", bus.pred_taken_o); end
    total++; if (bus.next_pc_o !== 32'h44) begin bad++; $display("FAIL rst_next_pc got=%h exp=00000044", bus.next_pc_o); end
    total++; if (bus.stat_upd_o !== 4'd0) begin bad++; $display("FAIL rst_stat_upd got=%0d exp=0", bus.stat_upd_o); end
    // Update offered while reset is held is dropped
    bus.upd_valid_i = 1'b1; bus.upd_pc_i = 32'h40; bus.upd_taken_i = 1'b1;
    bus.upd_target_i = 32'h80; bus.upd_mispred_i = 1'b1;
    @(posedge clk); @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    look(32'h40);
    total++; if (bus.pred_hit_o !== 1'b0) begin bad++; $display("FAIL rst_drop_hit got=%b exp=0", bus.pred_hit_o); end
    total++; if (bus.stat_miss_o !== 4'd0) begin bad++; $display("FAIL rst_drop_miss got=%0d exp=0", bus.stat_miss_o); end
  endtask

  task automatic test_allocate();
    upd(32'h40, 1'b1, 32'h80, 1'b1);
    look(32'h40);
    total++; if (bus.pred_hit_o !== 1'b1) begin bad++; $display("FAIL alloc_hit got=%b exp=1", bus.pred_hit_o); end
    total++; if (bus.pred_taken_o !== 1'b1) begin bad++; $display("FAIL alloc_taken got=%b exp=1", bus.pred_taken_o); end
    total++; if (bus.next_pc_o !== 32'h80) begin bad++; $display("FAIL alloc_next_pc got=%h exp=00000080", bus.next_pc_o); end
    total++; if (bus.stat_upd_o !== 4'd1) begin bad++; $display("FAIL alloc_stat_upd got=%0d exp=1", bus.stat_upd_o); end
    bus.en_i = 1'b0; #1;
    total++; if (bus.pred_hit_o !== 1'b1) begin bad++; $display("FAIL static_hit got=%b exp=1", bus.pred_hit_o); end
    total++; if (bus.pred_taken_o !== 1'b0) begin bad++; $display("FAIL static_taken got=%b exp=0", bus.pred_taken_o); end
    total++; if (bus.next_pc_o !== 32'h44) begin bad++; $display("FAIL static_next_pc got=%h exp=00000044", bus.next_pc_o); end
    bus.en_i = 1'b1; #1;
    look(32'hFFFF_FFFC);
    total++; if (bus.next_pc_o !== 32'h0) begin bad++; $display("FAIL wrap_next_pc got=%h exp=00000000", bus.next_pc_o); end
  endtask

  task automatic test_saturation();
    // Counter at weakly taken after allocate
    upd(32'h40, 1'b0, 32'h0, 1'b1);
    look(32'h40);
    total++; if (bus.pred_taken_o !== 1'b0) begin bad++; $display("FAIL sat_nt1_taken got=%b exp=0", bus.pred_taken_o); end
    total++; if (bus.next_pc_o !== 32'h44) begin bad++; $display("FAIL sat_nt1_next_pc got=%h exp=00000044", bus.next_pc_o); end
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look(32'h40);
    total++; if (bus.pred_hit_o !== 1'b1) begin bad++; $display("FAIL sat_nt3_hit got=%b exp=1", bus.pred_hit_o); end
    // From 00 one taken gives 01: still not-taken unless the counter wrapped
    upd(32'h40, 1'b1, 32'h100, 1'b1);
    look(32'h40);
    total++; if (bus.pred_taken_o !== 1'b0) begin bad++; $display("FAIL sat_t1_taken got=%b exp=0", bus.pred_taken_o); end
    upd(32'h40, 1'b1, 32'h100, 1'b1);
    look(32'h40);
    total++; if (bus.pred_taken_o !== 1'b1) begin bad++; $display("FAIL sat_t2_taken got=%b exp=1", bus.pred_taken_o); end
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    look(32'h40);
    total++; if (bus.next_pc_o !== 32'h100) begin bad++; $display("FAIL sat_t4_next_pc got=%h exp=00000100", bus.next_pc_o); end
    // 11 -> 10 keeps predicting taken; a wrap to 00 would not
    upd(32'h40, 1'b0, 32'h0, 1'b1);
    look(32'h40);
    total++; if (bus.pred_taken_o !== 1'b1) begin bad++; $display("FAIL sat_hi_taken got=%b exp=1", bus.pred_taken_o); end
  endtask

  task automatic test_alias();
    look(32'h80);
    total++; if (bus.pred_hit_o !== 1'b0) begin bad++; $display("FAIL alias_hit got=%b exp=0", bus.pred_hit_o); end
    total++; if (bus.next_pc_o !== 32'h84) begin bad++; $display("FAIL alias_next_pc got=%h exp=00000084", bus.next_pc_o); end
    upd(32'h80, 1'b0, 32'h0, 1'b0);
    look(32'h40);
    total++; if (bus.next_pc_o !== 32'h100) begin bad++; $display("FAIL alias_keep got=%h exp=00000100", bus.next_pc_o); end
    upd(32'h80, 1'b1, 32'h200, 1'b1);
    look(32'h80);
    total++; if (bus.next_pc_o !== 32'h200) begin bad++; $display("FAIL alias_repl_next_pc got=%h exp=00000200", bus.next_pc_o); end
    look(32'h40);
    total++; if (bus.pred_hit_o !== 1'b0) begin bad++; $display("FAIL alias_old_hit got=%b exp=0", bus.pred_hit_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    upd(32'h40, 1'b1, 32'h80, 1'b0);
    @(negedge clk);
    bus.pred_pc_i     = 32'h40;
    bus.upd_valid_i   = 1'b1;
    bus.upd_pc_i      = 32'h40;
    bus.upd_taken_i   = 1'b0;
    bus.upd_target_i  = 32'h0;
    bus.upd_mispred_i = 1'b1;
    #1;
    total++; if (bus.next_pc_o !== 32'h80) begin bad++; $display("FAIL same_cyc_old got=%h exp=00000080", bus.next_pc_o); end
    @(posedge clk); #1;
    bus.upd_valid_i = 1'b0;
    #1;
    total++; if (bus.pred_taken_o !== 1'b0) begin bad++; $display("FAIL same_cyc_new_taken got=%b exp=0", bus.pred_taken_o); end
    total++; if (bus.next_pc_o !== 32'h44) begin bad++; $display("FAIL same_cyc_new_pc got=%h exp=00000044", bus.next_pc_o); end
  endtask

  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      upd(32'h1000 + 32'(i * 4), 1'(i % 2), 32'h2000, 1'(i < 17));
      if (i == 9) begin
        total++; if (bus.stat_upd_o !== 4'd10) begin bad++; $display("FAIL stat_mid_upd got=%0d exp=10", bus.stat_upd_o); end
        total++; if (bus.stat_miss_o !== 4'd10) begin bad++; $display("FAIL stat_mid_miss got=%0d exp=10", bus.stat_miss_o); end
      end
    end
    total++; if (bus.stat_upd_o !== 4'd15) begin bad++; $display("FAIL stat_upd got=%0d exp=15", bus.stat_upd_o); end
    total++; if (bus.stat_miss_o !== 4'd15) begin bad++; $display("FAIL stat_miss got=%0d exp=15", bus.stat_miss_o); end
    @(negedge clk);
    bus.upd_valid_i   = 1'b0;
    bus.upd_mispred_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.upd_mispred_i = 1'b0;
    total++; if (bus.stat_miss_o !== 4'd15) begin bad++; $display("FAIL stat_novalid_miss got=%0d exp=15", bus.stat_miss_o); end
    upd(32'h3000, 1'b0, 32'h0, 1'b1);
    total++; if (bus.stat_upd_o !== 4'd15) begin bad++; $display("FAIL stat_hold_upd got=%0d exp=15", bus.stat_upd_o); end
    total++; if (bus.stat_miss_o !== 4'd15) begin bad++; $display("FAIL stat_hold_miss got=%0d exp=15", bus.stat_miss_o); end
  endtask

  task automatic test_stats_gate();
    do_reset();
    @(negedge clk);
    bus.upd_valid_i   = 1'b0;
    bus.upd_mispred_i = 1'b1;
    @(posedge clk); #1;
    bus.upd_mispred_i = 1'b0;
    total++; if (bus.stat_miss_o !== 4'd0) begin bad++; $display("FAIL stat_gate_miss got=%0d exp=0", bus.stat_miss_o); end
    upd(32'h10, 1'b0, 32'h0, 1'b0);
    total++; if (bus.stat_upd_o !== 4'd1) begin bad++; $display("FAIL stat_gate_upd got=%0d exp=1", bus.stat_upd_o); end
    total++; if (bus.stat_miss_o !== 4'd0) begin bad++; $display("FAIL stat_gate_nomis got=%0d exp=0", bus.stat_miss_o); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_allocate();
    test_saturation();
    test_alias();
    test_back_to_back();
    test_stats_gate();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
